bidir_dir_ctrl: RTL and testbench



---
 rtl/bidir_dir_ctrl.sv | 177 +++++++++++++++++
 tb/tb_bidir_dir_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/bidir_dir_ctrl.sv
// Direction controller for bidirectional_buff: arbitrates A->B / B->A requests and
// inserts dead turnaround cycles. Define BIDIR_STATS_EN to add the turn_cnt output.
module bidir_dir_ctrl #(
    parameter int TURN_CYCLES = 2,
    parameter int HOLD_MAX    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_ab,
    input  logic        req_ba,
    output logic        ctr,
    output logic        oe_a,
    output logic        oe_b,
    output logic        gnt_ab,
    output logic        gnt_ba,
    output logic        busy
`ifdef BIDIR_STATS_EN
    ,
    output logic [15:0] turn_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRV_AB = 2'd1,
        DRV_BA = 2'd2,
        TURN   = 2'd3
    } state_t;

    localparam logic       DIR_AB    = 1'b1;
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);
    localparam logic [3:0] TURN_LAST = 4'(TURN_CYCLES - 1);

    state_t     state_q, state_d;
    logic       ctr_q, ctr_d;
    logic       target_q, target_d;
    logic       ptr_q, ptr_d;
    logic [7:0] hold_q, hold_d;
    logic [3:0] turn_q, turn_d;
    logic       oe_a_q, oe_a_d;
    logic       oe_b_q, oe_b_d;
    logic       gnt_ab_q, gnt_ab_d;
    logic       gnt_ba_q, gnt_ba_d;
    logic       busy_q, busy_d;
    logic       enter_turn;
    logic       win;
    logic       drv_dir;
    logic       own_req;
    logic       opp_req;

    // NOTE: every variable gets a default first so no path through the case infers a latch.
    always_comb begin
        state_d    = state_q;
        ctr_d      = ctr_q;
        target_d   = target_q;
        ptr_d      = ptr_q;
        hold_d     = hold_q;
        turn_d     = turn_q;
        enter_turn = 1'b0;
        win        = (req_ab && req_ba) ? ptr_q : req_ab;
        drv_dir    = (state_q == DRV_AB);
        own_req    = drv_dir ? req_ab : req_ba;
        opp_req    = drv_dir ? req_ba : req_ab;

        case (state_q)
            IDLE: begin
                if (req_ab || req_ba) begin
                    if (win == ctr_q) begin
                        state_d = (win == DIR_AB) ? DRV_AB : DRV_BA;
                        hold_d  = '0;
                        ptr_d   = ~win;
                    end else begin
                        state_d    = TURN;
                        target_d   = win;
                        ctr_d      = win;
                        turn_d     = '0;
                        enter_turn = 1'b1;
                    end
                end
            end
            DRV_AB, DRV_BA: begin
                // A long-held grant is forced to yield once the waiting side hits HOLD_MAX.
                if (!own_req || (opp_req && hold_q == HOLD_LAST)) begin
                    if (opp_req) begin
                        state_d    = TURN;
                        target_d   = ~drv_dir;
                        ctr_d      = ~drv_dir;
                        turn_d     = '0;
                        enter_turn = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (opp_req) begin
                    hold_d = hold_q + 8'd1;
                end
            end
            TURN: begin
                if (turn_q == TURN_LAST) begin
                    if ((target_q == DIR_AB) ? req_ab : req_ba) begin
                        state_d = (target_q == DIR_AB) ? DRV_AB : DRV_BA;
                        hold_d  = '0;
                        ptr_d   = ~target_q;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    turn_d = turn_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d   = (state_d != IDLE);
        oe_a_d   = (state_d == DRV_AB);
        gnt_ab_d = (state_d == DRV_AB);
        oe_b_d   = (state_d == DRV_BA);
        gnt_ba_d = (state_d == DRV_BA);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            ctr_q    <= 1'b0;
            target_q <= 1'b0;
            ptr_q    <= DIR_AB;
            hold_q   <= '0;
            turn_q   <= '0;
            oe_a_q   <= 1'b0;
            oe_b_q   <= 1'b0;
            gnt_ab_q <= 1'b0;
            gnt_ba_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctr_q    <= ctr_d;
            target_q <= target_d;
            ptr_q    <= ptr_d;
            hold_q   <= hold_d;
            turn_q   <= turn_d;
            oe_a_q   <= oe_a_d;
            oe_b_q   <= oe_b_d;
            gnt_ab_q <= gnt_ab_d;
            gnt_ba_q <= gnt_ba_d;
            busy_q   <= busy_d;
        end
    end

    assign ctr    = ctr_q;
    assign oe_a   = oe_a_q;
    assign oe_b   = oe_b_q;
    assign gnt_ab = gnt_ab_q;
    assign gnt_ba = gnt_ba_q;
    assign busy   = busy_q;

`ifdef BIDIR_STATS_EN
    logic [15:0] turn_cnt_q, turn_cnt_d;

    always_comb begin
        turn_cnt_d = turn_cnt_q;
        if (enter_turn && turn_cnt_q != 16'hFFFF) begin
            turn_cnt_d = turn_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            turn_cnt_q <= '0;
        end else begin
            turn_cnt_q <= turn_cnt_d;
        end
    end

    assign turn_cnt = turn_cnt_q;
`endif

endmodule

// File: tb/tb_bidir_dir_ctrl.sv
// Scoreboard bench for bidir_dir_ctrl: stimulus pushes expected output vectors,
// a monitor pops and compares one entry per clock, #1 after the rising edge.
module tb_bidir_dir_ctrl;

    logic clk;
    logic rst;
    logic req_ab;
    logic req_ba;
    logic ctr, oe_a, oe_b, gnt_ab, gnt_ba, busy;
`ifdef BIDIR_STATS_EN
    logic [15:0] turn_cnt;
`endif

    bidir_dir_ctrl #(
        .TURN_CYCLES(2),
        .HOLD_MAX   (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req_ab  (req_ab),
        .req_ba  (req_ba),
        .ctr     (ctr),
        .oe_a    (oe_a),
        .oe_b    (oe_b),
        .gnt_ab  (gnt_ab),
        .gnt_ba  (gnt_ba),
        .busy    (busy)
`ifdef BIDIR_STATS_EN
        ,
        .turn_cnt(turn_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output vector order: {busy, ctr, oe_a, oe_b, gnt_ab, gnt_ba}
    localparam logic [5:0] IDLE0 = 6'b000000;
    localparam logic [5:0] IDLE1 = 6'b010000;
    localparam logic [5:0] DAB   = 6'b111010;
    localparam logic [5:0] DBA   = 6'b100101;
    localparam logic [5:0] TURN1 = 6'b110000;
    localparam logic [5:0] TURN0 = 6'b100000;

    typedef struct {
        string      name;
        logic [5:0] exp;
        int         tc;
    } sb_entry_t;

    sb_entry_t sb_q[$];
    sb_entry_t mon_e;
    logic [5:0] outs;
    int n_compared = 0;
    int n_failed   = 0;

    assign outs = {busy, ctr, oe_a, oe_b, gnt_ab, gnt_ba};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_failed++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Expected vector is what the outputs show after the next rising edge.
    task automatic step(input logic ab, input logic ba, input logic [5:0] exp,
                        input string name, input int tc = -1);
        @(negedge clk);
        req_ab = ab;
        req_ba = ba;
        sb_q.push_back('{name: name, exp: exp, tc: tc});
    endtask

    task automatic async_reset(input string name);
        @(negedge clk);
        #2;
        rst    = 1'b1;
        req_ab = 1'b0;
        req_ba = 1'b0;
        #1;
        check(name, 32'(outs), 32'(IDLE0));
`ifdef BIDIR_STATS_EN
        check({name, "_turn_cnt"}, 32'(turn_cnt), 32'd0);
`endif
        #1;
        rst = 1'b0;
    endtask

    always @(posedge clk) begin
        #1;
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            check(mon_e.name, 32'(outs), 32'(mon_e.exp));
`ifdef BIDIR_STATS_EN
            if (mon_e.tc >= 0) check({mon_e.name, "_turn_cnt"}, 32'(turn_cnt), 32'(mon_e.tc));
`endif
        end
        check("inv_oe_both", 32'(oe_a & oe_b), 32'd0);
        check("inv_oe_a_ctr", 32'(oe_a & ~ctr), 32'd0);
        check("inv_oe_b_ctr", 32'(oe_b & ctr), 32'd0);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst    = 1'b1;
        req_ab = 1'b0;
        req_ba = 1'b0;
        #3;
        check("reset_outs", 32'(outs), 32'(IDLE0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // 1: idle after reset
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, IDLE0, "t1_idle");

        // 2: B->A matches reset ctr=0, granted without TURN
        step(1'b0, 1'b1, DBA,   "t2_gnt_ba");
        step(1'b0, 1'b1, DBA,   "t2_hold_ba");
        step(1'b0, 1'b0, IDLE0, "t2_idle_ctr0");

        // 3: A->B needs a 2-cycle turnaround
        step(1'b1, 1'b0, TURN1, "t3_turn_a");
        step(1'b1, 1'b0, TURN1, "t3_turn_b");
        step(1'b1, 1'b0, DAB,   "t3_gnt_ab");
        step(1'b0, 1'b0, IDLE1, "t3_idle_ctr1");

        // 4: set up ctr=1 with pointer=AB (BA grant, then an abandoned turn to AB)
        step(1'b0, 1'b1, TURN0, "t4_pre_turn_a");
        step(1'b0, 1'b1, TURN0, "t4_pre_turn_b");
        step(1'b0, 1'b1, DBA,   "t4_pre_gnt_ba");
        step(1'b0, 1'b0, IDLE0, "t4_pre_idle");
        step(1'b1, 1'b0, TURN1, "t4_abort_turn");
        step(1'b0, 1'b0, TURN1, "t4_turn_continues");
        step(1'b0, 1'b0, IDLE1, "t4_turn_to_idle");
        step(1'b1, 1'b1, DAB,   "t4_both_ab_wins");
        step(1'b1, 1'b1, DAB,   "t4_ab_hold1");
        step(1'b1, 1'b1, DAB,   "t4_ab_hold2");
        step(1'b0, 1'b1, TURN0, "t4_turn_ba_a");
        step(1'b0, 1'b1, TURN0, "t4_turn_ba_b");
        step(1'b0, 1'b1, DBA,   "t4_gnt_ba");
        step(1'b0, 1'b0, IDLE0, "t4_idle");
        step(1'b1, 1'b1, TURN1, "t4_both_again_turn_a");
        step(1'b1, 1'b1, TURN1, "t4_both_again_turn_b");
        step(1'b1, 1'b0, DAB,   "t4_ab_wins_again");
        step(1'b1, 1'b0, DAB,   "t4_ab_alone");

        // 5: forced turnaround after 8 cycles of req_ba while req_ab holds
        for (int i = 0; i < 7; i++) step(1'b1, 1'b1, DAB, "t5_hold_ab");
        step(1'b1, 1'b1, TURN0, "t5_forced_turn");
        step(1'b1, 1'b1, TURN0, "t5_turn_b");
        step(1'b1, 1'b1, DBA,   "t5_gnt_ba");
        step(1'b0, 1'b0, IDLE0, "t5_idle");

        // 6: reset mid-TURN, then three counted turnarounds
        step(1'b1, 1'b0, TURN1, "t6_turn");
        async_reset("t6_rst_mid_turn");
        step(1'b0, 1'b0, IDLE0, "t6_after_rst", 0);
        step(1'b1, 1'b0, TURN1, "t6_turn1", 1);
        step(1'b1, 1'b0, TURN1, "t6_turn1_b");
        step(1'b1, 1'b0, DAB,   "t6_gnt_ab");
        step(1'b0, 1'b1, TURN0, "t6_turn2", 2);
        step(1'b0, 1'b1, TURN0, "t6_turn2_b");
        step(1'b0, 1'b1, DBA,   "t6_gnt_ba");
        step(1'b1, 1'b0, TURN1, "t6_turn3", 3);
        step(1'b1, 1'b0, TURN1, "t6_turn3_b");
        step(1'b1, 1'b0, DAB,   "t6_gnt_ab2");
        step(1'b0, 1'b0, IDLE1, "t6_idle", 3);
        async_reset("t6_rst_clears");

        @(posedge clk);
        #3;
        check("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

endmodule
